// File: rtl/battleship_turn_ctrl.sv
// Turn sequencer for the two-board Battleship game: placement, alternating fire,
// settle-then-check-alive, win display and restart.
module battleship_turn_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CW         = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       BTN1A,
    input  logic       BTN1B,
    input  logic       BTN2A,
    input  logic       BTN2B,
    input  logic       BTN3A,
    input  logic       BTN3B,
    input  logic       OKA,
    input  logic       OKB,
    input  logic       LivA,
    input  logic       LivB,
    output logic       STA,
    output logic       STB,
    output logic       LDR2A,
    output logic       LDR2B,
    output logic       dp_clr,
    output logic [2:0] DispA,
    output logic [2:0] DispB,
    output logic       turn,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_PLACE,
        S_TURN_A,
        S_SETTLE_A,
        S_TURN_B,
        S_SETTLE_B,
        S_WIN_A,
        S_WIN_B
    } state_t;

    localparam logic [2:0] D_PLAC = 3'd0;
    localparam logic [2:0] D_WAIT = 3'd1;
    localparam logic [2:0] D_FIRE = 3'd2;
    localparam logic [2:0] D_BAD  = 3'd3;
    localparam logic [2:0] D_WIN  = 3'd4;
    localparam logic [2:0] D_LOSE = 3'd5;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    // Button bit order: {BTN3B, BTN3A, BTN2B, BTN2A, BTN1B, BTN1A}
    logic [5:0] w_btnRaw;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_prev;
    logic [5:0] w_ev;

    assign w_btnRaw = {BTN3B, BTN3A, BTN2B, BTN2A, BTN1B, BTN1A};
    assign w_ev     = r_sync2 & ~r_prev;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_btnRaw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    state_t        r_state, w_nState;
    logic          r_rdyA, r_rdyB, w_nRdyA, w_nRdyB;
    logic          r_badA, r_badB, w_nBadA, w_nBadB;
    logic [CW-1:0] r_cnt, w_nCnt;
    logic          r_ldA, r_ldB, r_dpClr, w_nLdA, w_nLdB, w_nDpClr;
    logic [2:0]    r_dispA, r_dispB, w_nDispA, w_nDispB;
    logic          r_turn, r_gameOver, w_nTurn, w_nGameOver;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_PLACE;
            r_rdyA     <= 1'b0;
            r_rdyB     <= 1'b0;
            r_badA     <= 1'b0;
            r_badB     <= 1'b0;
            r_cnt      <= '0;
            r_ldA      <= 1'b0;
            r_ldB      <= 1'b0;
            r_dpClr    <= 1'b0;
            r_dispA    <= D_PLAC;
            r_dispB    <= D_PLAC;
            r_turn     <= 1'b0;
            r_gameOver <= 1'b0;
        end else begin
            r_state    <= w_nState;
            r_rdyA     <= w_nRdyA;
            r_rdyB     <= w_nRdyB;
            r_badA     <= w_nBadA;
            r_badB     <= w_nBadB;
            r_cnt      <= w_nCnt;
            r_ldA      <= w_nLdA;
            r_ldB      <= w_nLdB;
            r_dpClr    <= w_nDpClr;
            r_dispA    <= w_nDispA;
            r_dispB    <= w_nDispB;
            r_turn     <= w_nTurn;
            r_gameOver <= w_nGameOver;
        end
    end

    // Outputs are decoded from the next state so they land together with the transition.
    always_comb begin
        w_nState    = r_state;
        w_nRdyA     = r_rdyA;
        w_nRdyB     = r_rdyB;
        w_nBadA     = r_badA;
        w_nBadB     = r_badB;
        w_nCnt      = r_cnt;
        w_nLdA      = 1'b0;
        w_nLdB      = 1'b0;
        w_nDpClr    = 1'b0;
        w_nDispA    = D_PLAC;
        w_nDispB    = D_PLAC;
        w_nTurn     = 1'b0;
        w_nGameOver = 1'b0;

        case (r_state)
            S_PLACE: begin
                if (r_rdyA && r_rdyB) begin
                    w_nState = S_TURN_A;
                end else begin
                    if (w_ev[0]) w_nRdyA = 1'b1;
                    if (w_ev[1]) w_nRdyB = 1'b1;
                end
            end
            S_TURN_A: begin
                if (w_ev[2]) begin
                    if (OKA) begin
                        w_nLdA   = 1'b1;
                        w_nBadA  = 1'b0;
                        w_nCnt   = '0;
                        w_nState = S_SETTLE_A;
                    end else begin
                        w_nBadA = 1'b1;
                    end
                end
            end
            S_SETTLE_A: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_nState = LivB ? S_TURN_B : S_WIN_A;
                end else begin
                    w_nCnt = r_cnt + CW'(1);
                end
            end
            S_TURN_B: begin
                if (w_ev[3]) begin
                    if (OKB) begin
                        w_nLdB   = 1'b1;
                        w_nBadB  = 1'b0;
                        w_nCnt   = '0;
                        w_nState = S_SETTLE_B;
                    end else begin
                        w_nBadB = 1'b1;
                    end
                end
            end
            S_SETTLE_B: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_nState = LivA ? S_TURN_A : S_WIN_B;
                end else begin
                    w_nCnt = r_cnt + CW'(1);
                end
            end
            S_WIN_A, S_WIN_B: begin
                if (w_ev[4] || w_ev[5]) begin
                    w_nState = S_PLACE;
                    w_nRdyA  = 1'b0;
                    w_nRdyB  = 1'b0;
                    w_nBadA  = 1'b0;
                    w_nBadB  = 1'b0;
                    w_nDpClr = 1'b1;
                end
            end
            default: w_nState = S_PLACE;
        endcase

        case (w_nState)
            S_PLACE: begin
                w_nDispA = w_nRdyA ? D_WAIT : D_PLAC;
                w_nDispB = w_nRdyB ? D_WAIT : D_PLAC;
            end
            S_TURN_A: begin
                w_nDispA = w_nBadA ? D_BAD : D_FIRE;
                w_nDispB = D_WAIT;
            end
            S_SETTLE_A: begin
                w_nDispA = D_WAIT;
                w_nDispB = D_WAIT;
            end
            S_TURN_B: begin
                w_nDispA = D_WAIT;
                w_nDispB = w_nBadB ? D_BAD : D_FIRE;
                w_nTurn  = 1'b1;
            end
            S_SETTLE_B: begin
                w_nDispA = D_WAIT;
                w_nDispB = D_WAIT;
                w_nTurn  = 1'b1;
            end
            S_WIN_A: begin
                w_nDispA    = D_WIN;
                w_nDispB    = D_LOSE;
                w_nGameOver = 1'b1;
            end
            S_WIN_B: begin
                w_nDispA    = D_LOSE;
                w_nDispB    = D_WIN;
                w_nGameOver = 1'b1;
            end
            default: begin
                w_nDispA = D_PLAC;
                w_nDispB = D_PLAC;
            end
        endcase
    end

    assign STA       = r_rdyA;
    assign STB       = r_rdyB;
    assign LDR2A     = r_ldA;
    assign LDR2B     = r_ldB;
    assign dp_clr    = r_dpClr;
    assign DispA     = r_dispA;
    assign DispB     = r_dispB;
    assign turn      = r_turn;
    assign game_over = r_gameOver;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Randomized bench for battleship_turn_ctrl, checked every cycle against a
// game-level model of placement, turns, settle countdown and wins.
module tb_battleship_turn_ctrl;

    localparam int SETTLE_CYC = 2;
    localparam int CW         = 2;
    localparam int NUM_CYC    = 4000;

    logic       clk = 1'b0;
    logic       clr;
    logic [5:0] btn;
    logic       oka, okb, liva, livb;
    logic       sta, stb, ldr2a, ldr2b, dpClr, turn, gameOver;
    logic [2:0] dispA, dispB;

    int errors = 0;
    int checks = 0;
    int settleResets = 0;

    always #5 clk = ~clk;

    battleship_turn_ctrl #(.SETTLE_CYC(SETTLE_CYC), .CW(CW)) dut (
        .clk(clk), .clr(clr),
        .BTN1A(btn[0]), .BTN1B(btn[1]), .BTN2A(btn[2]), .BTN2B(btn[3]),
        .BTN3A(btn[4]), .BTN3B(btn[5]),
        .OKA(oka), .OKB(okb), .LivA(liva), .LivB(livb),
        .STA(sta), .STB(stb), .LDR2A(ldr2a), .LDR2B(ldr2b), .dp_clr(dpClr),
        .DispA(dispA), .DispB(dispB), .turn(turn), .game_over(gameOver)
    );

    // Game model: placing phase, per-player ready/bad, whose turn, settle countdown, winner (0 none, 1 A, 2 B)
    bit         placing;
    bit   [1:0] ready, bad, expLd;
    bit         expDpClr;
    int         whose, settleLeft, winner;
    bit   [5:0] d1, d2, d3;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        if (observed !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        placing = 1; ready = 0; bad = 0; expLd = 0; expDpClr = 0;
        whose = 0; settleLeft = 0; winner = 0;
        d1 = 0; d2 = 0; d3 = 0;
    endtask

    // A press becomes visible to the game two edges after it is sampled (synchronizer) and only once.
    task automatic modelStep();
        bit [5:0] ev;
        bit fire, ok;
        ev = d2 & ~d3;
        d3 = d2; d2 = d1; d1 = btn;
        expLd = 0; expDpClr = 0;
        if (winner != 0) begin
            if (ev[4] || ev[5]) begin
                winner = 0; placing = 1; ready = 0; bad = 0; expDpClr = 1;
            end
        end else if (placing) begin
            if (ready == 2'b11) begin
                placing = 0; whose = 0;
            end else begin
                if (ev[0]) ready[0] = 1;
                if (ev[1]) ready[1] = 1;
            end
        end else if (settleLeft > 0) begin
            settleLeft--;
            if (settleLeft == 0) begin
                if (whose == 0) begin
                    if (!livb) winner = 1; else whose = 1;
                end else begin
                    if (!liva) winner = 2; else whose = 0;
                end
            end
        end else begin
            fire = (whose == 0) ? ev[2] : ev[3];
            ok   = (whose == 0) ? oka : okb;
            if (fire) begin
                if (ok) begin
                    expLd[whose] = 1; bad[whose] = 0; settleLeft = SETTLE_CYC;
                end else begin
                    bad[whose] = 1;
                end
            end
        end
    endtask

    function automatic int expDisp(input int p);
        if (winner != 0) return (winner == p + 1) ? 4 : 5;
        if (placing) return ready[p] ? 1 : 0;
        if (settleLeft > 0) return 1;
        if (whose == p) return bad[p] ? 3 : 2;
        return 1;
    endfunction

    task automatic checkAll();
        checkOutput("STA", 32'(sta), int'(ready[0]));
        checkOutput("STB", 32'(stb), int'(ready[1]));
        checkOutput("LDR2A", 32'(ldr2a), int'(expLd[0]));
        checkOutput("LDR2B", 32'(ldr2b), int'(expLd[1]));
        checkOutput("dp_clr", 32'(dpClr), int'(expDpClr));
        checkOutput("DispA", 32'(dispA), expDisp(0));
        checkOutput("DispB", 32'(dispB), expDisp(1));
        checkOutput("game_over", 32'(gameOver), (winner != 0) ? 1 : 0);
        if (winner == 0) checkOutput("turn", 32'(turn), placing ? 0 : whose);
    endtask

    // Buttons toggle often enough to produce presses and long holds; Liv/OK occasionally drop.
    task automatic applyStimulus();
        for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 3) == 0) btn[b] = ~btn[b];
        oka  = ($urandom_range(0, 3) != 0);
        okb  = ($urandom_range(0, 3) != 0);
        liva = ($urandom_range(0, 4) != 0);
        livb = ($urandom_range(0, 4) != 0);
    endtask

    task automatic asyncReset();
        clr = 1'b1;
        #1;
        modelReset();
        checkAll();
        #1 clr = 1'b0;
    endtask

    initial begin
        btn = 0; oka = 0; okb = 0; liva = 1; livb = 1;
        clr = 1'b1;
        #2;
        modelReset();
        checkAll();
        #1 clr = 1'b0;
        for (int i = 0; i < NUM_CYC; i++) begin
            @(negedge clk);
            if ((settleResets < 3 && winner == 0 && !placing && settleLeft > 0 && i > 200 * (settleResets + 1))
                || $urandom_range(0, 499) == 0) begin
                if (settleLeft > 0) settleResets++;
                asyncReset();
            end
            applyStimulus();
            @(posedge clk);
            modelStep();
            #1 checkAll();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
